// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: one byte/halfword/word request is split into
// little-endian single-byte memory cycles and answered with one response pulse.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [7:0]        mem_write_data,
  input  logic [7:0]        mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_next;
  logic              write_q, signed_q, err_q;
  logic [1:0]        size_q, k, last_k;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rbuf, load_ext;
  logic              accept, misaligned;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    last_k = 2'd3;
    case (size_q)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = misaligned ? RESP : ACCESS;
      ACCESS:  if (k == last_k) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are latched only on accept, so req_* may change freely mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      k        <= 2'd0;
      rbuf     <= '0;
    end else if (accept) begin
      write_q  <= req_write;
      signed_q <= req_signed;
      err_q    <= misaligned;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      k        <= 2'd0;
      rbuf     <= '0;
    end else if (state == ACCESS) begin
      if (!write_q) rbuf[{k, 3'b000} +: 8] <= mem_read_data;
      k <= k + 2'd1;
    end
  end

  always_comb begin
    load_ext = rbuf;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rbuf[7]}}, rbuf[7:0]};
      2'b01:   load_ext = {{16{signed_q & rbuf[15]}}, rbuf[15:0]};
      default: load_ext = rbuf;
    endcase
  end

  // Outputs decode the state register directly so reset clears them asynchronously.
  always_comb begin
    req_ready      = (state == IDLE);
    mem_addr       = '0;
    mem_write_en   = 1'b0;
    mem_write_data = 8'h00;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = 32'h0;
    case (state)
      ACCESS: begin
        mem_addr     = addr_q + ADDR_W'(k);
        mem_write_en = write_q;
        if (write_q) mem_write_data = wdata_q[{k, 3'b000} +: 8];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!write_q && !err_q) resp_rdata = load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven requests against a byte
// memory model, a response scoreboard, and hand sequences for back-to-back and reset abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr;
  logic        mem_write_en;
  logic [7:0]  mem_write_data, mem_read_data;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          nwr;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t e;

  logic [7:0] mem [256];
  int cyc = 0;
  int wr_count = 0;
  int checks = 0;
  int errors = 0;

  // Byte memory: combinational read, write on rising edge.
  assign mem_read_data = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_en) begin
      mem[mem_addr[7:0]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest pending expectation, in its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_rdata"}, resp_rdata, e.rdata);
        checkOutput({e.name, "_err"}, 32'(resp_err), 32'(e.err));
        checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic addVec(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    int n;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    v.lat = exp_err ? 1 : n + 1;
    v.nwr = (wr && !exp_err) ? n : 0;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
  endtask

  task automatic pushExp(input vec_t v, input int accept_cyc);
    exp_t x;
    x.rdata = v.exp_rdata; x.err = v.exp_err; x.cyc = accept_cyc - 1 + v.lat; x.name = v.name;
    exp_q.push_back(x);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int n = 0;
    int wr0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checkOutput({v.name, "_ready_timeout"}, 32'(req_ready), 32'd1);
      return;
    end
    drive(v);
    req_valid = 1'b1;
    wr0 = wr_count;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pushExp(v, cyc);
    waitDrain(v.name);
    checkOutput({v.name, "_writes"}, 32'(wr_count - wr0), 32'(v.nwr));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t a, b;
    int acc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    addVec(1, 2'b10, 0, 32'h10, 32'hA1B2C3D4, 32'h0,        0, "st_w_10");
    addVec(0, 2'b10, 0, 32'h10, 32'h0,        32'hA1B2C3D4, 0, "ld_w_10");
    addVec(0, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFFA1, 0, "ld_b_13_s");
    addVec(0, 2'b00, 0, 32'h13, 32'h0,        32'h000000A1, 0, "ld_b_13_u");
    addVec(0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFFA1B2, 0, "ld_h_12_s");
    addVec(0, 2'b01, 0, 32'h12, 32'h0,        32'h0000A1B2, 0, "ld_h_12_u");
    addVec(0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1, "ld_h_11_err");
    addVec(1, 2'b10, 0, 32'h12, 32'h55667788, 32'h0,        1, "st_w_12_err");
    addVec(0, 2'b11, 0, 32'h40, 32'h0,        32'h0,        1, "ld_rsvd_err");
    addVec(1, 2'b01, 0, 32'h20, 32'h12345678, 32'h0,        0, "st_h_20");
    addVec(0, 2'b01, 1, 32'h20, 32'h0,        32'h00005678, 0, "ld_h_20_s");
    addVec(1, 2'b00, 0, 32'h31, 32'hFFFFFF80, 32'h0,        0, "st_b_31");
    addVec(0, 2'b00, 1, 32'h31, 32'h0,        32'hFFFFFF80, 0, "ld_b_31_s");
    addVec(0, 2'b10, 1, 32'h30, 32'h0,        32'h00008000, 0, "ld_w_30_s");
    addVec(0, 2'b01, 1, 32'h30, 32'h0,        32'hFFFF8000, 0, "ld_h_30_s");

    // Reset with a request pending: nothing may be accepted or reported.
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_we", 32'(mem_write_en), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_writes", 32'(wr_count), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].name == "st_w_10") begin
        checkOutput("mem_10", 32'(mem[8'h10]), 32'hD4);
        checkOutput("mem_11", 32'(mem[8'h11]), 32'hC3);
        checkOutput("mem_12", 32'(mem[8'h12]), 32'hB2);
        checkOutput("mem_13", 32'(mem[8'h13]), 32'hA1);
      end
    end

    // Back-to-back with req_valid held high; second request is only taken after RESP.
    a = vecs[3]; a.name = "b2b_first";
    b = vecs[5]; b.name = "b2b_second";
    @(negedge clk);
    drive(a);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    pushExp(a, acc);
    drive(b);
    @(negedge clk);
    checkOutput("b2b_ready_access", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_idle", 32'(req_ready), 32'd1);
    checkOutput("b2b_accept_cycle", 32'(cyc), 32'(acc + 2));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pushExp(b, cyc);
    waitDrain("b2b");

    // Reset asserted during the second byte of a word store to 0x20.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_we", 32'(mem_write_en), 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'd0);
    checkOutput("abort_mem_wdata", 32'(mem_write_data), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_mem_20", 32'(mem[8'h20]), 32'hEF);
    checkOutput("abort_mem_21", 32'(mem[8'h21]), 32'h56);
    a = vecs[1];
    a.addr = 32'h20; a.exp_rdata = 32'h000056EF; a.name = "post_abort_ld_w_20";
    applyStimulus(a);

    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
